// File: rtl/rom_bus_ctrl.sv
// i4001 ROM bus-cycle controller: follows the eight-phase instruction cycle from SYNC,
// captures the two address nibbles and returns the ROM byte as two nibbles in M1/M2.
module rom_bus_ctrl #(
  parameter logic [3:0] CHIP_ID = 4'h0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       sync,
  input  logic       cm_rom,
  input  logic [3:0] din,
  input  logic [7:0] rom_data,
  output logic [7:0] addr,
  output logic [3:0] dout,
  output logic       doe,
  output logic [2:0] phase,
  output logic       locked,
  output logic       sync_err
);

  typedef enum logic [2:0] {
    PH_A1 = 3'd0,
    PH_A2 = 3'd1,
    PH_A3 = 3'd2,
    PH_M1 = 3'd3,
    PH_M2 = 3'd4,
    PH_X1 = 3'd5,
    PH_X2 = 3'd6,
    PH_X3 = 3'd7
  } phase_t;

  phase_t     phase_q, phase_d;
  logic       locked_q;
  logic       sync_err_q;
  logic       sel_q;
  logic [3:0] addr_lo_tmp_q;
  logic [7:0] addr_q;
  logic [3:0] dout_q;

  // Capture strobes; a SYNC cycle abandons whatever partial bus cycle was in flight.
  logic       active;
  logic       cap_lo, cap_addr, cap_sel, cap_lo_nib, clr_sel;
  logic       early_sync;

  always_comb begin
    phase_d    = phase_q;
    active     = locked_q && !sync;
    cap_lo     = 1'b0;
    cap_addr   = 1'b0;
    cap_sel    = 1'b0;
    cap_lo_nib = 1'b0;
    clr_sel    = 1'b0;
    early_sync = sync && locked_q && (phase_q != PH_X3);

    if (sync) begin
      phase_d = PH_A1;
    end else if (locked_q) begin
      unique case (phase_q)
        PH_A1:   phase_d = PH_A2;
        PH_A2:   phase_d = PH_A3;
        PH_A3:   phase_d = PH_M1;
        PH_M1:   phase_d = PH_M2;
        PH_M2:   phase_d = PH_X1;
        PH_X1:   phase_d = PH_X2;
        PH_X2:   phase_d = PH_X3;
        PH_X3:   phase_d = PH_A1;
        default: phase_d = PH_A1;
      endcase
    end

    if (active) begin
      cap_lo     = (phase_q == PH_A1);
      cap_addr   = (phase_q == PH_A2);
      cap_sel    = (phase_q == PH_A3);
      cap_lo_nib = (phase_q == PH_M1);
      clr_sel    = (phase_q == PH_M2);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      phase_q       <= PH_A1;
      locked_q      <= 1'b0;
      sync_err_q    <= 1'b0;
      sel_q         <= 1'b0;
      addr_lo_tmp_q <= 4'h0;
      addr_q        <= 8'h00;
      dout_q        <= 4'h0;
    end else begin
      phase_q <= phase_d;
      if (sync) begin
        locked_q <= 1'b1;
        sel_q    <= 1'b0;
      end
      if (early_sync) sync_err_q <= 1'b1;
      if (cap_lo) addr_lo_tmp_q <= din;
      if (cap_addr) addr_q <= {din, addr_lo_tmp_q};
      if (cap_sel) begin
        sel_q  <= (din == CHIP_ID) && cm_rom;
        dout_q <= rom_data[7:4];
      end
      if (cap_lo_nib) dout_q <= rom_data[3:0];
      if (clr_sel) sel_q <= 1'b0;
    end
  end

  // Bus drive: dout is meaningful only while doe is high (M1 high nibble, M2 low nibble).
  assign doe      = sel_q && ((phase_q == PH_M1) || (phase_q == PH_M2));
  assign addr     = addr_q;
  assign dout     = dout_q;
  assign phase    = phase_q;
  assign locked   = locked_q;
  assign sync_err = sync_err_q;

endmodule

// File: tb/tb_rom_bus_ctrl.sv
// Directed and randomized bench for rom_bus_ctrl; expected bus data comes from a
// per-transaction model (address, chip match, ROM contents) held in a scoreboard queue.
module tb_rom_bus_ctrl;

  localparam logic [3:0] CHIP = 4'h3;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       sync;
  logic       cm_rom;
  logic [3:0] din;
  logic [7:0] rom_data;
  logic [7:0] addr;
  logic [3:0] dout;
  logic       doe;
  logic [2:0] phase;
  logic       locked;
  logic       sync_err;

  int total = 0;
  int bad   = 0;

  logic [4:0] exp_q[$];

  rom_bus_ctrl #(.CHIP_ID(CHIP)) dut (
    .clk(clk), .rst_n(rst_n), .sync(sync), .cm_rom(cm_rom), .din(din),
    .rom_data(rom_data), .addr(addr), .dout(dout), .doe(doe), .phase(phase),
    .locked(locked), .sync_err(sync_err)
  );

  // clock / reset
  always #5 clk = ~clk;

  function automatic logic [7:0] rom_model(input logic [7:0] a);
    return ~a;
  endfunction

  // ROM array stand-in: combinational from the controller's address
  assign rom_data = rom_model(addr);

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_phase"}, 32'(phase), 32'd0);
    chk({tag, "_locked"}, 32'(locked), 32'd0);
    chk({tag, "_doe"}, 32'(doe), 32'd0);
    chk({tag, "_addr"}, 32'(addr), 32'd0);
    chk({tag, "_dout"}, 32'(dout), 32'd0);
    chk({tag, "_err"}, 32'(sync_err), 32'd0);
  endtask

  task automatic pop_chk(input string tag);
    logic [4:0] e;
    if (exp_q.size() == 0) begin
      chk({tag, "_q_empty"}, 32'd1, 32'd0);
    end else begin
      e = exp_q.pop_front();
      chk({tag, "_doe"}, 32'(doe), 32'(e[4]));
      chk({tag, "_dout"}, 32'(dout), 32'(e[3:0]));
    end
  endtask

  // Drives A1..A3 from phase A1; leaves the DUT in M1 with the expected M1/M2 bus words queued.
  task automatic drive_addr(input logic [7:0] a, input logic [3:0] id, input logic cm);
    logic       s;
    logic [7:0] r;
    din = a[3:0];
    tick();
    chk("a2_phase", 32'(phase), 32'd1);
    din = a[7:4];
    tick();
    chk("a3_phase", 32'(phase), 32'd2);
    chk("a3_addr", 32'(addr), 32'(a));
    din = id;
    cm_rom = cm;
    s = (id == CHIP) && cm;
    r = rom_model(a);
    exp_q.push_back({s, r[7:4]});
    exp_q.push_back({s, r[3:0]});
    tick();
    din = 4'h0;
    cm_rom = 1'b0;
    chk("m1_phase", 32'(phase), 32'd3);
  endtask

  // One full 8-phase cycle starting in A1, with SYNC driven during X3.
  task automatic bus_cycle(input logic [7:0] a, input logic [3:0] id, input logic cm);
    drive_addr(a, id, cm);
    pop_chk("m1");
    tick();
    pop_chk("m2");
    tick();
    chk("x1_doe", 32'(doe), 32'd0);
    chk("x1_addr", 32'(addr), 32'(a));
    tick();
    tick();
    chk("x3_phase", 32'(phase), 32'd7);
    sync = 1'b1;
    tick();
    sync = 1'b0;
    chk("a1_phase", 32'(phase), 32'd0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (3) tick();
    rst_n = 1'b1;
  endtask

  initial begin
    logic [7:0] a;
    logic [3:0] id;
    logic       cm;
    rst_n = 1'b0; sync = 1'b0; cm_rom = 1'b0; din = 4'h0;

    // reset then free-run without SYNC
    do_reset();
    chk_idle("rst");
    for (int i = 0; i < 10; i++) begin
      din = 4'($urandom_range(0, 15));
      cm_rom = 1'($urandom_range(0, 1));
      tick();
      chk_idle("nosync");
    end
    cm_rom = 1'b0;

    // first SYNC locks without flagging an error
    sync = 1'b1;
    tick();
    sync = 1'b0;
    chk("lock_locked", 32'(locked), 32'd1);
    chk("lock_phase", 32'(phase), 32'd0);
    chk("lock_err", 32'(sync_err), 32'd0);

    // basic fetch, then the two deselect variants
    bus_cycle(8'hA5, CHIP, 1'b1);
    bus_cycle(8'hA5, 4'h2, 1'b1);
    bus_cycle(8'hA5, CHIP, 1'b0);

    // back-to-back
    bus_cycle(8'h12, CHIP, 1'b1);
    bus_cycle(8'hFE, CHIP, 1'b1);
    chk("b2b_err", 32'(sync_err), 32'd0);

    // randomized cycles
    for (int i = 0; i < 16; i++) begin
      a  = 8'($urandom_range(0, 255));
      id = ($urandom_range(0, 1) == 1) ? CHIP : 4'($urandom_range(0, 15));
      cm = 1'($urandom_range(0, 3) != 0);
      bus_cycle(a, id, cm);
    end
    chk("rand_err", 32'(sync_err), 32'd0);

    // early SYNC during M1 of a selected cycle
    drive_addr(8'h3C, CHIP, 1'b1);
    pop_chk("em1");
    void'(exp_q.pop_front());
    sync = 1'b1;
    tick();
    sync = 1'b0;
    chk("early_phase", 32'(phase), 32'd0);
    chk("early_doe", 32'(doe), 32'd0);
    chk("early_err", 32'(sync_err), 32'd1);
    chk("early_addr", 32'(addr), 32'h3C);
    bus_cycle(8'h5A, CHIP, 1'b1);
    chk("early_err_sticky", 32'(sync_err), 32'd1);

    // reset in M1 of a selected cycle, with SYNC asserted to check reset priority
    drive_addr(8'h77, CHIP, 1'b1);
    pop_chk("rm1");
    void'(exp_q.pop_front());
    rst_n = 1'b0;
    sync = 1'b1;
    tick();
    rst_n = 1'b1;
    sync = 1'b0;
    chk_idle("midrst");
    for (int i = 0; i < 10; i++) begin
      din = 4'($urandom_range(0, 15));
      tick();
      chk_idle("postrst");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
